antares_fetch_unit: RTL and testbench

- Instruction-fetch stage and PC owner. Consumes the ID-stage branch decision (id_take_branch, pc_branch_address) and redirects fetch after the MIPS branch delay slot.
- Drives the instruction-memory request/ready handshake and buffers one fetched word while the pipeline is stalled.
- Produces the registered IF/ID outputs: instruction, PC, PC+4 and valid.
- Takes exception redirects from COP0 at highest priority.

---
 rtl/antares_fetch_unit_pkg.sv | 18 +
 rtl/antares_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_antares_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/antares_fetch_unit_pkg.sv
// Shared types and constants for the Antares instruction-fetch stage.
// State encodings, reset vector and the bubble instruction word.
package antares_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] ANTARES_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] ANTARES_NOP_WORD     = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/antares_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake,
// buffers one word across ID stalls and honours the branch delay slot.
module antares_fetch_unit
    import antares_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = ANTARES_RESET_VECTOR,
    parameter logic [31:0] NOP_WORD     = ANTARES_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        id_take_branch,
    input  logic [31:0] pc_branch_address,
    input  logic        exc_redirect,
    input  logic [31:0] exc_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_add4,
    output logic        id_valid
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] pending_target_r;
    logic        redirect_pending_r;
    logic [31:0] hold_buf_r;
    logic [31:0] drain_addr_r;
    logic [31:0] id_instruction_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc_add4_r;
    logic        id_valid_r;

    logic        issue_s;
    logic        save_hold_s;
    logic        bubble_s;
    logic        branch_ok_s;
    logic        start_drain_s;
    logic [31:0] issue_word_s;
    logic [31:0] pc_add4_s;
    logic [31:0] next_pc_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an exception outranks stall and memory response
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (exc_redirect) begin
                    state_nxt_s = imem_ready ? S_FETCH : S_DRAIN;
                end else if (imem_ready && id_stall) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_HOLD: begin
                state_nxt_s = (exc_redirect || !id_stall) ? S_FETCH : S_HOLD;
            end
            S_DRAIN: begin
                state_nxt_s = (!exc_redirect && imem_ready) ? S_FETCH : S_DRAIN;
            end
            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

    // Per-state datapath decisions and the memory request outputs
    always_comb begin
        issue_s       = 1'b0;
        save_hold_s   = 1'b0;
        start_drain_s = 1'b0;
        issue_word_s  = imem_rdata;
        imem_addr     = pc_r;
        case (state_r)
            S_FETCH: begin
                issue_s       = !exc_redirect && !id_stall && imem_ready;
                save_hold_s   = !exc_redirect && id_stall && imem_ready;
                start_drain_s = exc_redirect && !imem_ready;
            end
            S_HOLD: begin
                issue_s      = !exc_redirect && !id_stall;
                issue_word_s = hold_buf_r;
            end
            S_DRAIN: begin
                imem_addr = drain_addr_r;
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
        imem_req = !rst && (state_r != S_HOLD);
    end

    assign branch_ok_s = id_take_branch && id_valid_r && !id_stall && !exc_redirect;
    assign bubble_s    = exc_redirect || (!id_stall && !issue_s);
    assign pc_add4_s   = pc_r + 32'd4;

    // PC selection: exception, then branch with slot issuing now, then pending, then sequential
    always_comb begin
        next_pc_s = pc_r;
        if (exc_redirect) begin
            next_pc_s = word_align(exc_address);
        end else if (issue_s && branch_ok_s) begin
            next_pc_s = word_align(pc_branch_address);
        end else if (issue_s && redirect_pending_r) begin
            next_pc_s = pending_target_r;
        end else if (issue_s) begin
            next_pc_s = pc_add4_s;
        end else begin
            next_pc_s = pc_r;
        end
    end

    // PC, redirect bookkeeping, hold buffer and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r               <= RESET_VECTOR;
            redirect_pending_r <= 1'b0;
            pending_target_r   <= 32'd0;
            hold_buf_r         <= 32'd0;
            drain_addr_r       <= 32'd0;
            id_instruction_r   <= NOP_WORD;
            id_pc_r            <= 32'd0;
            id_pc_add4_r       <= 32'd0;
            id_valid_r         <= 1'b0;
        end else begin
            pc_r <= next_pc_s;
            if (exc_redirect || issue_s) begin
                redirect_pending_r <= 1'b0;
            end else if (branch_ok_s) begin
                redirect_pending_r <= 1'b1;
                pending_target_r   <= word_align(pc_branch_address);
            end
            if (save_hold_s) begin
                hold_buf_r <= imem_rdata;
            end
            if (start_drain_s) begin
                drain_addr_r <= pc_r;
            end
            if (issue_s) begin
                id_instruction_r <= issue_word_s;
                id_pc_r          <= pc_r;
                id_pc_add4_r     <= pc_add4_s;
                id_valid_r       <= 1'b1;
            end else if (bubble_s) begin
                id_instruction_r <= NOP_WORD;
                id_valid_r       <= 1'b0;
            end
        end
    end

    assign id_instruction = id_instruction_r;
    assign id_pc          = id_pc_r;
    assign id_pc_add4     = id_pc_add4_r;
    assign id_valid       = id_valid_r;

endmodule

// File: tb/tb_antares_fetch_unit.sv
// Directed self-checking bench for antares_fetch_unit with a combinational
// instruction memory whose word content is a fixed function of the address.
module tb_antares_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        id_take_branch;
    logic [31:0] pc_branch_address;
    logic        exc_redirect;
    logic [31:0] exc_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add4;
    logic        id_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    antares_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .id_stall          (id_stall),
        .id_take_branch    (id_take_branch),
        .pc_branch_address (pc_branch_address),
        .exc_redirect      (exc_redirect),
        .exc_address       (exc_address),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .id_instruction    (id_instruction),
        .id_pc             (id_pc),
        .id_pc_add4        (id_pc_add4),
        .id_valid          (id_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_stall = 1'b0; id_take_branch = 1'b0; pc_branch_address = 32'd0;
        exc_redirect = 1'b0; exc_address = 32'd0; imem_ready = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_addr got=%h exp=bfc00000", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        checks++; if (id_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", id_instruction); end
        checks++; if (id_pc !== 32'h0 || id_pc_add4 !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h/%h exp=0/0", id_pc, id_pc_add4); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 32'hBFC0_0000 + 32'd4 * i;
            checks++; if (id_pc !== exp_pc || id_valid !== 1'b1) begin errors++; $display("FAIL seq_pc%0d got=%h v=%b exp=%h v=1", i, id_pc, id_valid, exp_pc); end
            checks++; if (id_instruction !== mem_word(exp_pc) || id_pc_add4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_word%0d got=%h/%h exp=%h/%h", i, id_instruction, id_pc_add4, mem_word(exp_pc), exp_pc + 32'd4); end
            checks++; if (imem_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, exp_pc + 32'd4); end
        end
    endtask

    task automatic test_branch();
        tick();
        checks++; if (id_pc !== 32'hBFC0_0010 || imem_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL br_setup got=%h/%h exp=bfc00010/bfc00014", id_pc, imem_addr); end
        id_take_branch = 1'b1; pc_branch_address = 32'hBFC0_0103;
        tick();
        id_take_branch = 1'b0;
        checks++; if (id_pc !== 32'hBFC0_0014 || id_valid !== 1'b1) begin errors++; $display("FAIL br_slot got=%h v=%b exp=bfc00014 v=1", id_pc, id_valid); end
        checks++; if (imem_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL br_target_addr got=%h exp=bfc00100", imem_addr); end
        tick();
        checks++; if (id_pc !== 32'hBFC0_0100 || imem_addr !== 32'hBFC0_0104) begin errors++; $display("FAIL br_target_issue got=%h/%h exp=bfc00100/bfc00104", id_pc, imem_addr); end
    endtask

    task automatic test_branch_wait();
        imem_ready = 1'b0; id_take_branch = 1'b1; pc_branch_address = 32'hBFC0_0200;
        tick();
        id_take_branch = 1'b0; pc_branch_address = 32'h0;
        checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0) begin errors++; $display("FAIL brw_bubble got v=%b i=%h exp v=0 i=0", id_valid, id_instruction); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0104) begin errors++; $display("FAIL brw_stable%0d got=%b/%h exp=1/bfc00104", i, imem_req, imem_addr); end
            if (i < 2) tick();
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (id_pc !== 32'hBFC0_0104 || id_valid !== 1'b1 || id_instruction !== mem_word(32'hBFC0_0104)) begin errors++; $display("FAIL brw_slot got=%h v=%b i=%h exp=bfc00104 v=1", id_pc, id_valid, id_instruction); end
        checks++; if (imem_addr !== 32'hBFC0_0200) begin errors++; $display("FAIL brw_target got=%h exp=bfc00200", imem_addr); end
        tick();
        checks++; if (id_pc !== 32'hBFC0_0200 || imem_addr !== 32'hBFC0_0204) begin errors++; $display("FAIL brw_next got=%h/%h exp=bfc00200/bfc00204", id_pc, imem_addr); end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hBFC0_0204) begin errors++; $display("FAIL stall_req%0d got=%b/%h exp=0/bfc00204", i, imem_req, imem_addr); end
            checks++; if (id_pc !== 32'hBFC0_0200 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=%h v=%b exp=bfc00200 v=1", i, id_pc, id_valid); end
        end
        id_stall = 1'b0;
        tick();
        checks++; if (id_pc !== 32'hBFC0_0204 || id_instruction !== mem_word(32'hBFC0_0204)) begin errors++; $display("FAIL stall_release got=%h i=%h exp=bfc00204 i=%h", id_pc, id_instruction, mem_word(32'hBFC0_0204)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0208) begin errors++; $display("FAIL stall_resume got=%b/%h exp=1/bfc00208", imem_req, imem_addr); end
        tick();
        checks++; if (id_pc !== 32'hBFC0_0208) begin errors++; $display("FAIL stall_next got=%h exp=bfc00208", id_pc); end
    endtask

    task automatic test_exception();
        imem_ready = 1'b0;
        tick();
        exc_redirect = 1'b1; exc_address = 32'h8000_0180;
        tick();
        exc_redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_020C) begin errors++; $display("FAIL exc_drain_addr got=%b/%h exp=1/bfc0020c", imem_req, imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'hBFC0_020C || id_valid !== 1'b0) begin errors++; $display("FAIL exc_drain_wait got=%h v=%b exp=bfc0020c v=0", imem_addr, id_valid); end
        imem_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0) begin errors++; $display("FAIL exc_discard got v=%b i=%h exp v=0 i=0", id_valid, id_instruction); end
        checks++; if (imem_addr !== 32'h8000_0180) begin errors++; $display("FAIL exc_vector got=%h exp=80000180", imem_addr); end
        tick();
        checks++; if (id_pc !== 32'h8000_0180 || id_valid !== 1'b1 || imem_addr !== 32'h8000_0184) begin errors++; $display("FAIL exc_issue got=%h v=%b a=%h exp=80000180 v=1 a=80000184", id_pc, id_valid, imem_addr); end
    endtask

    task automatic test_reset_in_drain();
        imem_ready = 1'b0;
        tick();
        exc_redirect = 1'b1; exc_address = 32'h8000_1000;
        tick();
        exc_redirect = 1'b0;
        checks++; if (imem_addr !== 32'h8000_0184) begin errors++; $display("FAIL rd_drain got=%h exp=80000184", imem_addr); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rd_reset got=%b/%h exp=0/bfc00000", imem_req, imem_addr); end
        checks++; if (id_pc !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL rd_outputs got=%h v=%b exp=0 v=0", id_pc, id_valid); end
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rd_fetch got=%b/%h exp=1/bfc00000", imem_req, imem_addr); end
        tick();
        checks++; if (id_pc !== 32'hBFC0_0000 || id_valid !== 1'b1) begin errors++; $display("FAIL rd_issue got=%h v=%b exp=bfc00000 v=1", id_pc, id_valid); end
    endtask

    task automatic test_exc_beats_branch();
        id_take_branch = 1'b1; pc_branch_address = 32'hBFC0_0300;
        exc_redirect = 1'b1; exc_address = 32'h8000_0180; id_stall = 1'b1;
        tick();
        id_take_branch = 1'b0; exc_redirect = 1'b0; id_stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h8000_0180) begin errors++; $display("FAIL eb_redirect got v=%b a=%h exp v=0 a=80000180", id_valid, imem_addr); end
        tick();
        checks++; if (id_pc !== 32'h8000_0180) begin errors++; $display("FAIL eb_issue got=%h exp=80000180", id_pc); end
        tick();
        checks++; if (id_pc !== 32'h8000_0184 || imem_addr !== 32'h8000_0188) begin errors++; $display("FAIL eb_no_branch got=%h/%h exp=80000184/80000188", id_pc, imem_addr); end
    endtask

    task automatic test_wrap();
        exc_redirect = 1'b1; exc_address = 32'hFFFF_FFFF;
        tick();
        exc_redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_add4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_add4 got=%h/%h/%h exp=fffffffc/0/0", id_pc, id_pc_add4, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_branch_wait();
        test_stall();
        test_exception();
        test_reset_in_drain();
        test_exc_beats_branch();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
